// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronizes and filters the PS/2 clock/data pair, checks the
// start, odd-parity and stop bits, and queues good bytes in a first-word-fall-through FIFO.
module ps2_rx #(
    parameter int FIFO_BITS = 3,
    parameter int FILTER    = 4,
    parameter int TIMEOUT   = 4096
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    input  logic                 rd,
    output logic [7:0]           dout,
    output logic                 empty,
    output logic [FIFO_BITS:0]   count,
    output logic                 overflow,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int TW    = $clog2(TIMEOUT) + 1;
    localparam logic [FIFO_BITS:0] FULL_CNT = (FIFO_BITS+1)'(DEPTH);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]         FILT_LAST = 4'(FILTER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_n;
    logic [1:0]            clk_s, data_s;
    logic                  clk_filt, clk_filt_d;
    logic [3:0]            filt_cnt;
    logic                  fall, din;
    logic [TW-1:0]         tmo_cnt;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic                  par_acc, par_ok;
    logic                  push, perr_set, ferr_set;
    logic [7:0]            mem [DEPTH];
    logic [FIFO_BITS-1:0]  wptr, rptr;
    logic [FIFO_BITS:0]    cnt;
    logic                  full, do_pop, do_push;

    // Input synchronizers and glitch filter on the PS/2 clock
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s      <= 2'b11;
            data_s     <= 2'b11;
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_s      <= {clk_s[0], ps2_clk};
            data_s     <= {data_s[0], ps2_data};
            clk_filt_d <= clk_filt;
            if (clk_s[1] != clk_filt) begin
                if (filt_cnt == FILT_LAST) begin
                    clk_filt <= clk_s[1];
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 4'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;
    assign din  = data_s[1];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        push     = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        if (state != S_IDLE && !fall && tmo_cnt == TMO_LAST) begin
            state_n  = S_IDLE;
            ferr_set = 1'b1;
        end else if (fall) begin
            case (state)
                S_IDLE:   if (!din) state_n = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_n = S_PARITY;
                S_PARITY: state_n = S_STOP;
                S_STOP: begin
                    state_n = S_IDLE;
                    if (!din)         ferr_set = 1'b1;
                    else if (!par_ok) perr_set = 1'b1;
                    else              push     = 1'b1;
                end
                default:  state_n = S_IDLE;
            endcase
        end
    end

    // tmo_cnt counts cycles since the last fall, the fall cycle itself being cycle 0
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            par_ok     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= perr_set;
            frame_err  <= ferr_set;
            if (fall || state == S_IDLE) tmo_cnt <= TW'(1);
            else                         tmo_cnt <= tmo_cnt + 1'b1;
            if (fall) begin
                case (state)
                    S_IDLE: begin
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                    end
                    S_DATA: begin
                        shreg   <= {din, shreg[7:1]};
                        par_acc <= par_acc ^ din;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_ok <= par_acc ^ din;
                    default: ;
                endcase
            end
        end
    end

    // Consumer side: dout is valid whenever empty=0; rd pops the head on the
    // rising edge when the FIFO is non-empty and is ignored otherwise.
    assign full    = (cnt == FULL_CNT);
    assign do_pop  = rd && (cnt != '0);
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push && full && !do_pop) overflow <= 1'b1;
        end
    end

    assign count = cnt;
    assign empty = (cnt == '0);
    assign dout  = empty ? 8'h00 : mem[rptr];

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed frames from the test plan followed by random
// frames checked against a queue model of the receive FIFO.
module tb_ps2_rx;

    localparam int FIFO_BITS = 3;
    localparam int FILTER    = 4;
    localparam int TIMEOUT   = 4096;
    localparam int DEPTH     = 1 << FIFO_BITS;
    localparam int HALF      = 21;
    localparam int FALL_LAT  = FILTER + 2;

    logic                 clk_sys  = 1'b0;
    logic                 reset_n  = 1'b0;
    logic                 ps2_clk  = 1'b1;
    logic                 ps2_data = 1'b1;
    logic                 rd       = 1'b0;
    logic [7:0]           dout;
    logic                 empty;
    logic [FIFO_BITS:0]   count;
    logic                 overflow;
    logic                 parity_err;
    logic                 frame_err;

    int errors = 0;
    int checks = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;

    ps2_rx #(.FIFO_BITS(FIFO_BITS), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd         (rd),
        .dout       (dout),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (parity_err) perr_cnt++;
        if (frame_err)  ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    // rd_at_push raises rd for the single cycle in which a good byte is written
    task automatic send_frame(input logic [7:0] b, input logic par_flip,
                              input logic stop_val, input logic rd_at_push);
        logic [7:0] bb;
        logic       p;
        bb = b;
        p  = (($countones(bb) % 2) == 0) ^ par_flip;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(bb[i]);
        ps2_bit(p);
        ps2_data = stop_val;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        for (int k = 1; k <= HALF; k++) begin
            @(negedge clk_sys);
            rd = (rd_at_push && k == FALL_LAT);
        end
        rd = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk_sys);
    endtask

    task automatic pop();
        @(negedge clk_sys);
        rd = 1'b1;
        @(negedge clk_sys);
        rd = 1'b0;
    endtask

    initial begin
        int p0, f0, first;
        logic [7:0] q[$];
        logic ov_m;

        // reset state
        repeat (5) @(negedge clk_sys);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_dout", dout, 0);
        check("rst_ovf", overflow, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk_sys);

        // single good frame 0x1C
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("f1c_empty", empty, 0);
        check("f1c_count", count, 1);
        check("f1c_dout", dout, 8'h1C);
        check("f1c_perr", perr_cnt - p0, 0);
        check("f1c_ferr", ferr_cnt - f0, 0);
        pop();
        check("f1c_pop_empty", empty, 1);
        check("f1c_pop_count", count, 0);

        // two frames, FIFO order
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("two_count", count, 2);
        check("two_dout0", dout, 8'hF0);
        pop();
        check("two_dout1", dout, 8'h1C);
        pop();
        check("two_empty", empty, 1);

        // parity error then stop-bit error
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        check("perr_pulse", perr_cnt - p0, 1);
        check("perr_count", count, 0);
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        check("ferr_pulse", ferr_cnt - f0, 1);
        check("ferr_noperr", perr_cnt - p0, 0);
        check("ferr_count", count, 0);

        // timeout: start plus three data bits, then the clock stays high
        f0 = ferr_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        first = -1;
        for (int k = 1; k <= FALL_LAT + TIMEOUT + 10; k++) begin
            @(negedge clk_sys);
            if (k == HALF) ps2_clk = 1'b1;
            if (frame_err && first < 0) first = k;
        end
        check("tmo_when", first, FALL_LAT + TIMEOUT);
        check("tmo_pulses", ferr_cnt - f0, 1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("tmo_next_dout", dout, 8'h5A);
        check("tmo_next_count", count, 1);
        pop();

        // overflow: nine frames into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        check("ovf_count", count, DEPTH);
        check("ovf_flag", overflow, 1);
        for (int i = 1; i <= DEPTH; i++) begin
            check("ovf_dout", dout, i);
            pop();
        end
        check("ovf_empty", empty, 1);
        check("ovf_sticky", overflow, 1);

        // short clock glitch while idle with data low
        p0 = perr_cnt; f0 = ferr_cnt;
        ps2_data = 1'b0;
        @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (30) @(negedge clk_sys);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk_sys);
        check("glitch_count", count, 0);
        send_frame(8'h33, 1'b0, 1'b1, 1'b0);
        check("glitch_dout", dout, 8'h33);
        check("glitch_count2", count, 1);
        check("glitch_errs", (perr_cnt - p0) + (ferr_cnt - f0), 0);

        // reset in the middle of a frame
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_empty", empty, 1);
        check("mid_rst_count", count, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_errs", {parity_err, frame_err}, 0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk_sys);
        p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        check("after_rst_dout", dout, 8'h12);
        check("after_rst_count", count, 1);
        check("after_rst_errs", (perr_cnt - p0) + (ferr_cnt - f0), 0);
        pop();

        // random frames against a queue model
        ov_m = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int kind, npop;
            logic flip, stopv, rdp, full_before, popped;
            b     = 8'($urandom_range(0, 255));
            kind  = $urandom_range(0, 7);
            flip  = (kind == 0);
            stopv = (kind != 1);
            rdp   = ($urandom_range(0, 3) == 0);
            p0 = perr_cnt; f0 = ferr_cnt;
            send_frame(b, flip, stopv, rdp);
            full_before = (q.size() == DEPTH);
            popped = rdp && (q.size() > 0);
            if (popped) void'(q.pop_front());
            if (stopv && !flip) begin
                if (full_before && !popped) ov_m = 1'b1;
                else q.push_back(b);
            end
            check("rnd_count", count, q.size());
            check("rnd_dout", dout, (q.size() > 0) ? q[0] : 8'h00);
            check("rnd_ovf", overflow, ov_m);
            check("rnd_perr", perr_cnt - p0, (stopv && flip) ? 1 : 0);
            check("rnd_ferr", ferr_cnt - f0, stopv ? 0 : 1);
            npop = (n < 20) ? (($urandom_range(0, 3) == 0) ? 1 : 0) : $urandom_range(0, 3);
            for (int j = 0; j < npop; j++) begin
                pop();
                if (q.size() > 0) void'(q.pop_front());
                check("rnd_pop_count", count, q.size());
                check("rnd_pop_dout", dout, (q.size() > 0) ? q[0] : 8'h00);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- Core-side PS/2 receiver. Deserializes the ps2_kbd_clk/ps2_kbd_data or ps2_mouse_clk/ps2_mouse_data pairs produced by the IO-controller PS/2 emulation into bytes.
- Checks start, odd parity and stop bits, and buffers good bytes in a small first-word-fall-through FIFO read by the keyboard/mouse decoder.
- One instance per PS/2 channel. Fully synchronous to clk_sys.

Parameters:
- FIFO_BITS, 3: FIFO depth is 2**FIFO_BITS bytes.
- FILTER, 4: consecutive identical synced samples needed before the filtered ps2_clk changes value (1..15).
- TIMEOUT, 4096: clk_sys cycles without a ps2_clk falling edge mid-frame before the frame is aborted (must exceed 2*FILTER+PS/2 clock period).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  PS/2 clock line, asynchronous, idles high.
- ps2_data  in  1  PS/2 data line, asynchronous.
- rd  in  1  pop strobe; pops one byte per cycle while high and !empty.
- dout  out  8  head-of-FIFO byte; valid when empty=0.
- empty  out  1  FIFO empty.
- count  out  FIFO_BITS+1  bytes held, 0..2**FIFO_BITS.
- overflow  out  1  sticky: a good byte was dropped because the FIFO was full.
- parity_err  out  1  one-cycle pulse: frame dropped, parity wrong.
- frame_err  out  1  one-cycle pulse: frame dropped, stop bit 0 or timeout.

Behaviour:
- Reset (async, reset_n=0): state IDLE, FIFO pointers 0, empty=1, count=0, overflow=0, parity_err=0, frame_err=0, dout=8'h00 (memory contents don't-care, dout masked to 0 while empty). Synchronizers and filter preset to 1. Reset mid-frame discards the partial byte.
- Input path: 2-FF synchronizer on ps2_clk and on ps2_data.
  - Filtered clk toggles only after FILTER consecutive synced samples differ from its current value.
  - A falling edge of filtered clk produces a one-cycle `fall` strobe. The synced data value is sampled in that cycle.
- State machine, advancing only on `fall`:
  - IDLE: data=0 -> DATA with bit_cnt=0. Data=1 -> remain in IDLE, no error.
  - DATA: shreg <= {data, shreg[7:1]} (LSB first); parity accumulator toggles on each 1; after bit_cnt=7 -> PARITY.
  - PARITY: record the parity bit. Parity is OK when the 8 data bits plus the parity bit contain an odd number of ones. -> STOP.
  - STOP, data=1 and parity OK: push shreg into the FIFO.
  - STOP, parity bad: pulse parity_err; byte dropped.
  - STOP, data=0: pulse frame_err; byte dropped (stop-bit error takes precedence over parity error). All STOP cases -> IDLE.
- Timeout: cycle counter cleared on every `fall` and while in IDLE. If the counter reaches TIMEOUT-1 in any non-IDLE state: -> IDLE, pulse frame_err, partial byte dropped.
- Error pulses are asserted in the cycle after the deciding `fall`, for exactly 1 cycle.
- Push latency: the byte is written in the cycle after the stop-bit `fall`. empty falls, count increments and dout is valid in the same cycle.
- FIFO, first-word fall-through: dout = mem[rptr]. rd while empty is ignored.
  - Push while full and rd=0: byte dropped, overflow <= 1. Overflow stays set until reset.
  - Push and rd together while full: both happen, count unchanged, no overflow.
  - Push and rd together while empty: rd ignored, push accepted.
  - Pointers wrap modulo 2**FIFO_BITS. count is exact, including the full state (count = 2**FIFO_BITS).
- Throughput: a back-to-back frame may start on the `fall` immediately following the stop bit.

Test Plan:
- Reset, then frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at clk_sys/42 bit rate -> empty=0, count=1, dout=8'h1C, no error pulses. rd pulse -> empty=1, count=0.
- Frames 0xF0 (parity 1) then 0x1C -> dout=0xF0. Pop -> dout=0x1C. Pop -> empty=1.
- 0x1C sent with parity 1 -> parity_err pulses once, count stays 0. 0x5A sent with stop 0 -> frame_err pulses once, count 0.
- Start plus 3 data bits, then clock held high -> frame_err exactly TIMEOUT cycles after the last `fall`. Next good frame 0x5A received correctly.
- FIFO_BITS=3: send 9 frames 0x01..0x09 with no reads -> count=8, overflow=1. Pops return 0x01..0x08 in order, then empty=1.
- 2-cycle low glitch on ps2_clk in IDLE with ps2_data=0 -> no state change. Assert reset_n=0 mid-frame -> all outputs return to reset values immediately. The next frame, 0x12, is received correctly.
